// File: rtl/conv_ddr_packer.sv
// Packs PACK_NUM serial samples into DDR-width words, flushing partial words at eof, and queues them in a FIFO for the DDR writer.
// Optional macro CONV_DDR_PACKER_OVF_CNT_EN adds a sticky overflow flag and a saturating drop counter.
module conv_ddr_packer #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    PACK_NUM     = 8,
    parameter int                    DEPTH_WORDS  = 84,
    parameter int                    AFULL_THRESH = DEPTH_WORDS / 2,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE    = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DATA_WIDTH-1:0]                data_i,
    input  logic                                 data_valid_i,
    input  logic                                 sop_i,
    input  logic                                 eop_i,
    input  logic                                 sof_i,
    input  logic                                 eof_i,
    input  logic                                 ddr_fifo_rd,
    output logic [DATA_WIDTH*PACK_NUM-1:0]       ddr_data_o,
    output logic                                 ddr_valid_o,
    output logic                                 ddr_eof_o,
    output logic                                 ddr_fifo_empty,
    output logic                                 ddr_fifo_full,
    output logic                                 ddr_fifo_afull,
    output logic [$clog2(DEPTH_WORDS+1)-1:0]     level_o,
`ifdef CONV_DDR_PACKER_OVF_CNT_EN
    output logic                                 ovf_o,
    output logic [15:0]                          ovf_cnt_o,
`endif
    output logic                                 frame_err_o
);
    localparam int WW  = DATA_WIDTH * PACK_NUM;
    localparam int LW  = $clog2(DEPTH_WORDS + 1);
    localparam int PW  = $clog2(DEPTH_WORDS);
    localparam int LCW = $clog2(PACK_NUM);
    localparam logic [LCW-1:0] LAST_LANE = LCW'(PACK_NUM - 1);

    logic [LCW-1:0] lane;
    logic [LCW-1:0] eff_lane;
    logic [WW-1:0]  pack_reg;
    logic [WW-1:0]  merged;
    logic           complete;
    logic [WW-1:0]  word_q;
    logic           word_eof;
    logic           word_vld;
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic           rd_ok;
    logic           wr_en;
    logic           drop;
    logic [WW:0]    mem [DEPTH_WORDS];

    // Row boundaries do not break packing; the framing bits are accepted for interface compatibility only.
    logic unused_framing;
    assign unused_framing = &{1'b0, sop_i, eop_i};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH_WORDS - 1)) ? '0 : p + 1'b1;
    endfunction

    // A sof mid-word throws away the partial word, so the sof sample restarts at lane 0.
    always_comb begin
        merged   = '0;
        eff_lane = (sof_i && lane != '0) ? '0 : lane;
        for (int k = 0; k < PACK_NUM; k++) begin
            if (LCW'(k) < eff_lane)
                merged[k*DATA_WIDTH +: DATA_WIDTH] = pack_reg[k*DATA_WIDTH +: DATA_WIDTH];
            else if (LCW'(k) == eff_lane)
                merged[k*DATA_WIDTH +: DATA_WIDTH] = data_i;
            else
                merged[k*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
        end
        complete = data_valid_i && (eff_lane == LAST_LANE || eof_i);
    end

    // Read handshake: ddr_fifo_rd is a request, accepted only when the FIFO holds a word;
    // each accepted request yields exactly one ddr_valid_o pulse in the following cycle.
    // A full FIFO still takes a word when a read frees a slot in the same cycle.
    assign rd_ok = ddr_fifo_rd && (level_o != '0);
    assign wr_en = word_vld && ((level_o != LW'(DEPTH_WORDS)) || rd_ok);
    assign drop  = word_vld && !wr_en;
    assign ddr_fifo_empty = (level_o == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane        <= '0;
            pack_reg    <= '0;
            word_q      <= '0;
            word_eof    <= 1'b0;
            word_vld    <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            word_vld <= 1'b0;
            if (data_valid_i) begin
                pack_reg <= merged;
                if (sof_i && lane != '0)
                    frame_err_o <= 1'b1;
                if (complete) begin
                    lane     <= '0;
                    word_q   <= merged;
                    word_eof <= eof_i;
                    word_vld <= 1'b1;
                end else begin
                    lane <= eff_lane + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr] <= {word_eof, word_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr           <= '0;
            rptr           <= '0;
            level_o        <= '0;
            ddr_data_o     <= '0;
            ddr_eof_o      <= 1'b0;
            ddr_valid_o    <= 1'b0;
            ddr_fifo_full  <= 1'b0;
            ddr_fifo_afull <= 1'b0;
        end else begin
            ddr_valid_o <= rd_ok;
            if (rd_ok) begin
                {ddr_eof_o, ddr_data_o} <= mem[rptr];
                rptr <= ptr_inc(rptr);
            end
            if (wr_en)
                wptr <= ptr_inc(wptr);
            unique case ({wr_en, rd_ok})
                2'b10:   level_o <= level_o + 1'b1;
                2'b01:   level_o <= level_o - 1'b1;
                default: level_o <= level_o;
            endcase
            // Flags follow the registered level, so they trail it by one cycle.
            ddr_fifo_full  <= (level_o == LW'(DEPTH_WORDS));
            ddr_fifo_afull <= (level_o >= LW'(AFULL_THRESH));
        end
    end

`ifdef CONV_DDR_PACKER_OVF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_o     <= 1'b0;
            ovf_cnt_o <= '0;
        end else if (drop) begin
            ovf_o <= 1'b1;
            if (ovf_cnt_o != 16'hFFFF)
                ovf_cnt_o <= ovf_cnt_o + 16'd1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && drop)
            $error("conv_ddr_packer: word dropped, FIFO full");
    end
`endif
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_conv_ddr_packer.sv
// Directed bench for conv_ddr_packer: packing, eof flush, sof error, FIFO full/afull timing, read/write collision, mid-frame reset.
module tb_conv_ddr_packer;
    localparam int DW = 8;
    localparam int PN = 8;
    localparam int WW = DW * PN;
    localparam int DEPTH = 4;
    localparam int LW = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_i = '0;
    logic          data_valid_i = 1'b0;
    logic          sop_i = 1'b0;
    logic          eop_i = 1'b0;
    logic          sof_i = 1'b0;
    logic          eof_i = 1'b0;
    logic          ddr_fifo_rd = 1'b0;
    logic [WW-1:0] ddr_data_o;
    logic          ddr_valid_o;
    logic          ddr_eof_o;
    logic          ddr_fifo_empty;
    logic          ddr_fifo_full;
    logic          ddr_fifo_afull;
    logic [LW-1:0] level_o;
    logic          frame_err_o;
`ifdef CONV_DDR_PACKER_OVF_CNT_EN
    logic          ovf_o;
    logic [15:0]   ovf_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    conv_ddr_packer #(
        .DATA_WIDTH(DW), .PACK_NUM(PN), .DEPTH_WORDS(DEPTH), .AFULL_THRESH(2), .PAD_VALUE(8'h00)
    ) dut (
        .clk(clk), .reset(reset), .data_i(data_i), .data_valid_i(data_valid_i),
        .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
        .ddr_fifo_rd(ddr_fifo_rd), .ddr_data_o(ddr_data_o), .ddr_valid_o(ddr_valid_o),
        .ddr_eof_o(ddr_eof_o), .ddr_fifo_empty(ddr_fifo_empty), .ddr_fifo_full(ddr_fifo_full),
        .ddr_fifo_afull(ddr_fifo_afull), .level_o(level_o),
`ifdef CONV_DDR_PACKER_OVF_CNT_EN
        .ovf_o(ovf_o), .ovf_cnt_o(ovf_cnt_o),
`endif
        .frame_err_o(frame_err_o)
    );

    always #5 clk = ~clk;

    // Word number w carries lane bytes {w, lane} in hex, e.g. w=1 -> 0x1716151413121110.
    function automatic logic [WW-1:0] exp_word(input int w);
        logic [WW-1:0] r;
        r = '0;
        for (int k = 0; k < PN; k++)
            r[k*DW +: DW] = DW'(w * 16 + k);
        return r;
    endfunction

    // Called at a negedge; the sample is captured at the next posedge.
    task automatic drive(input logic [DW-1:0] d, input logic s, input logic e);
        data_i = d; data_valid_i = 1'b1; sof_i = s; eof_i = e;
        sop_i = s; eop_i = e;
        @(negedge clk);
        data_valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    endtask

    task automatic push_word(input int w);
        for (int k = 0; k < PN; k++)
            drive(DW'(w * 16 + k), 1'b0, 1'b0);
    endtask

    task automatic do_read(output logic [WW-1:0] d, output logic e, output logic v);
        ddr_fifo_rd = 1'b1;
        @(negedge clk);
        ddr_fifo_rd = 1'b0;
        d = ddr_data_o; e = ddr_eof_o; v = ddr_valid_o;
    endtask

    task automatic check_reset_values(input string tag);
        checks += 8;
        if (ddr_data_o !== '0) begin errors++; $display("FAIL %s data got %h want 0", tag, ddr_data_o); end
        if (ddr_valid_o !== 1'b0) begin errors++; $display("FAIL %s valid got %b want 0", tag, ddr_valid_o); end
        if (ddr_eof_o !== 1'b0) begin errors++; $display("FAIL %s eof got %b want 0", tag, ddr_eof_o); end
        if (ddr_fifo_empty !== 1'b1) begin errors++; $display("FAIL %s empty got %b want 1", tag, ddr_fifo_empty); end
        if (ddr_fifo_full !== 1'b0) begin errors++; $display("FAIL %s full got %b want 0", tag, ddr_fifo_full); end
        if (ddr_fifo_afull !== 1'b0) begin errors++; $display("FAIL %s afull got %b want 0", tag, ddr_fifo_afull); end
        if (level_o !== '0) begin errors++; $display("FAIL %s level got %0d want 0", tag, level_o); end
        if (frame_err_o !== 1'b0) begin errors++; $display("FAIL %s frame_err got %b want 0", tag, frame_err_o); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
    endtask

    task automatic test_full_words;
        logic [WW-1:0] d; logic e; logic v;
        for (int i = 1; i <= 16; i++)
            drive(DW'(i), 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (level_o !== LW'(2)) begin errors++; $display("FAIL full_words level got %0d want 2", level_o); end
        do_read(d, e, v);
        checks += 3;
        if (v !== 1'b1) begin errors++; $display("FAIL full_words valid0 got %b want 1", v); end
        if (d !== 64'h0807060504030201) begin errors++; $display("FAIL full_words word0 got %h want 0807060504030201", d); end
        if (e !== 1'b0) begin errors++; $display("FAIL full_words eof0 got %b want 0", e); end
        do_read(d, e, v);
        checks += 3;
        if (v !== 1'b1) begin errors++; $display("FAIL full_words valid1 got %b want 1", v); end
        if (d !== 64'h100F0E0D0C0B0A09) begin errors++; $display("FAIL full_words word1 got %h want 100f0e0d0c0b0a09", d); end
        if (e !== 1'b0) begin errors++; $display("FAIL full_words eof1 got %b want 0", e); end
        checks++;
        if (ddr_fifo_empty !== 1'b1) begin errors++; $display("FAIL full_words empty got %b want 1", ddr_fifo_empty); end
    endtask

    task automatic test_flush;
        logic [WW-1:0] d; logic e; logic v;
        drive(8'hA1, 1'b1, 1'b0);
        drive(8'hA2, 1'b0, 1'b0);
        drive(8'hA3, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (level_o !== LW'(1)) begin errors++; $display("FAIL flush level got %0d want 1", level_o); end
        do_read(d, e, v);
        checks += 3;
        if (v !== 1'b1) begin errors++; $display("FAIL flush valid got %b want 1", v); end
        if (d !== 64'h0000000000A3A2A1) begin errors++; $display("FAIL flush word got %h want 0000000000a3a2a1", d); end
        if (e !== 1'b1) begin errors++; $display("FAIL flush eof got %b want 1", e); end
    endtask

    task automatic test_sof_error;
        logic [WW-1:0] d; logic e; logic v;
        for (int i = 0; i < 5; i++)
            drive(DW'(8'h11 + i), 1'b0, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++)
            drive(DW'(8'h56 + i), 1'b0, 1'b0);
        @(negedge clk);
        checks += 2;
        if (frame_err_o !== 1'b1) begin errors++; $display("FAIL sof frame_err got %b want 1", frame_err_o); end
        if (level_o !== LW'(1)) begin errors++; $display("FAIL sof level got %0d want 1", level_o); end
        do_read(d, e, v);
        checks += 2;
        if (d[7:0] !== 8'h55) begin errors++; $display("FAIL sof lane0 got %h want 55", d[7:0]); end
        if (d !== 64'h5C5B5A5958575655) begin errors++; $display("FAIL sof word got %h want 5c5b5a5958575655", d); end
    endtask

    task automatic test_full_drop;
        int exp_level;
        for (int w = 1; w <= 6; w++) begin
            push_word(w);
            @(negedge clk);
            exp_level = (w < DEPTH) ? w : DEPTH;
            checks++;
            if (level_o !== LW'(exp_level)) begin errors++; $display("FAIL drop level w%0d got %0d want %0d", w, level_o, exp_level); end
            if (w == 2) begin
                checks++;
                if (ddr_fifo_afull !== 1'b0) begin errors++; $display("FAIL drop afull_lag got %b want 0", ddr_fifo_afull); end
            end
            @(negedge clk);
            checks += 2;
            if (ddr_fifo_afull !== (w >= 2)) begin errors++; $display("FAIL drop afull w%0d got %b want %b", w, ddr_fifo_afull, w >= 2); end
            if (ddr_fifo_full !== (w >= 4)) begin errors++; $display("FAIL drop full w%0d got %b want %b", w, ddr_fifo_full, w >= 4); end
        end
`ifdef CONV_DDR_PACKER_OVF_CNT_EN
        checks += 2;
        if (ovf_cnt_o !== 16'd2) begin errors++; $display("FAIL drop ovf_cnt got %0d want 2", ovf_cnt_o); end
        if (ovf_o !== 1'b1) begin errors++; $display("FAIL drop ovf got %b want 1", ovf_o); end
`endif
    endtask

    task automatic test_back_to_back;
        logic [WW-1:0] d; logic e; logic v;
        int order[4] = '{2, 3, 4, 7};
        for (int k = 0; k < PN - 1; k++)
            drive(DW'(8'h70 + k), 1'b0, 1'b0);
        drive(8'h77, 1'b0, 1'b0);
        // The completed word hits the FIFO on the same edge as this read.
        do_read(d, e, v);
        checks += 3;
        if (v !== 1'b1) begin errors++; $display("FAIL rw valid got %b want 1", v); end
        if (d !== exp_word(1)) begin errors++; $display("FAIL rw oldest got %h want %h", d, exp_word(1)); end
        if (level_o !== LW'(4)) begin errors++; $display("FAIL rw level got %0d want 4", level_o); end
        for (int i = 0; i < 4; i++) begin
            do_read(d, e, v);
            checks += 2;
            if (v !== 1'b1) begin errors++; $display("FAIL drain valid%0d got %b want 1", i, v); end
            if (d !== exp_word(order[i])) begin errors++; $display("FAIL drain word%0d got %h want %h", i, d, exp_word(order[i])); end
        end
        do_read(d, e, v);
        checks += 3;
        if (v !== 1'b0) begin errors++; $display("FAIL empty_read valid got %b want 0", v); end
        if (d !== exp_word(7)) begin errors++; $display("FAIL empty_read hold got %h want %h", d, exp_word(7)); end
        if (ddr_fifo_empty !== 1'b1) begin errors++; $display("FAIL empty_read empty got %b want 1", ddr_fifo_empty); end
    endtask

    task automatic test_reset_midframe;
        logic [WW-1:0] d; logic e; logic v;
        for (int w = 1; w <= 3; w++)
            push_word(w);
        for (int k = 0; k < 4; k++)
            drive(DW'(8'h90 + k), 1'b0, 1'b0);
        checks++;
        if (level_o !== LW'(3)) begin errors++; $display("FAIL midreset pre_level got %0d want 3", level_o); end
        reset = 1'b1;
        #1;
        check_reset_values("midreset_async");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        push_word(11);
        @(negedge clk);
        checks++;
        if (level_o !== LW'(1)) begin errors++; $display("FAIL midreset level got %0d want 1", level_o); end
        do_read(d, e, v);
        checks += 2;
        if (d !== 64'hBAB9B8B7B6B5B4B3 - 64'h0303030303030303) begin errors++; $display("FAIL midreset word got %h want b7b6b5b4b3b2b1b0", d); end
        if (e !== 1'b0) begin errors++; $display("FAIL midreset eof got %b want 0", e); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_words();
        test_flush();
        test_sof_error();
        test_full_drop();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
